// File: rtl/wr_arria10_phy_rst_ctrl_pkg.sv
// wr_arria10_phy_rst_ctrl_pkg: state codes, default timing constants and state-to-pin decode
package wr_arria10_phy_rst_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_CAL   = 4'd1,
        S_TX_ANALOG  = 4'd2,
        S_TX_PLL     = 4'd3,
        S_RX_ANALOG  = 4'd4,
        S_RX_LTR     = 4'd5,
        S_RX_LTD     = 4'd6,
        S_RX_DIGITAL = 4'd7,
        S_READY      = 4'd9
    } state_t;

    localparam int C_SYNC_STAGES    = 2;
    localparam int C_ANALOG_CYCLES  = 16;
    localparam int C_DIGITAL_CYCLES = 16;
    localparam int C_LTD_STABLE     = 1024;
    localparam int C_TIMEOUT_CYCLES = 2**20;

    typedef struct packed {
        logic tx_ana_rst;
        logic tx_dig_rst;
        logic rx_ana_rst;
        logic rx_dig_rst;
        logic ltr;
        logic tx_rdy;
        logic rx_rdy;
    } ctrl_t;

    // Resets are released only in the states listed, so an unknown code keeps everything in reset
    // and a ready flag can never be set while its matching reset is asserted.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        logic tx_dig_rel, tx_ana_rel, rx_ana_rel, rx_dig_rel;
        tx_dig_rel   = s inside {S_RX_ANALOG, S_RX_LTR, S_RX_LTD, S_RX_DIGITAL, S_READY};
        tx_ana_rel   = tx_dig_rel || s == S_TX_PLL;
        rx_ana_rel   = s inside {S_RX_LTR, S_RX_LTD, S_RX_DIGITAL, S_READY};
        rx_dig_rel   = s == S_READY;
        c.tx_ana_rst = !tx_ana_rel;
        c.tx_dig_rst = !tx_dig_rel;
        c.rx_ana_rst = !rx_ana_rel;
        c.rx_dig_rst = !rx_dig_rel;
        c.ltr        = s == S_RX_LTR;
        c.tx_rdy     = tx_dig_rel;
        c.rx_rdy     = rx_dig_rel;
        return c;
    endfunction

endpackage

// File: rtl/wr_arria10_phy_rst_ctrl_if.sv
// wr_arria10_phy_rst_ctrl_if: transceiver PHY reset/CDR control pins and status pins
interface wr_arria10_phy_rst_ctrl_if;

    logic pll_locked;
    logic tx_cal_busy;
    logic rx_cal_busy;
    logic rx_is_lockedtoref;
    logic rx_is_lockedtodata;
    logic tx_analogreset;
    logic tx_digitalreset;
    logic rx_analogreset;
    logic rx_digitalreset;
    logic rx_set_locktoref;
    logic rx_set_locktodata;

    modport master (
        input  pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtoref, rx_is_lockedtodata,
        output tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
               rx_set_locktoref, rx_set_locktodata
    );

    modport slave (
        output pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtoref, rx_is_lockedtodata,
        input  tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
               rx_set_locktoref, rx_set_locktodata
    );

endinterface

// File: rtl/wr_arria10_phy_rst_ctrl_sync.sv
// wr_arria10_phy_rst_ctrl_sync: multi-stage flip-flop synchroniser for one asynchronous status bit
module wr_arria10_phy_rst_ctrl_sync #(
    parameter int g_stages = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic [g_stages-1:0] sync_q;

    // Plain shift chain; no reset so the chain tracks the pin while the block is held in reset.
    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[g_stages-2:0], d_i};
    end

    assign q_o = sync_q[g_stages-1];

endmodule

// File: rtl/wr_arria10_phy_rst_ctrl.sv
// wr_arria10_phy_rst_ctrl: Arria10 WR PHY reset/calibration/CDR-lock sequencer
module wr_arria10_phy_rst_ctrl
    import wr_arria10_phy_rst_ctrl_pkg::*;
#(
    parameter int g_sync_stages    = C_SYNC_STAGES,
    parameter int g_analog_cycles  = C_ANALOG_CYCLES,
    parameter int g_digital_cycles = C_DIGITAL_CYCLES,
    parameter int g_ltd_stable     = C_LTD_STABLE,
    parameter int g_timeout_cycles = C_TIMEOUT_CYCLES
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              phy_rst_i,
    wr_arria10_phy_rst_ctrl_if.master         phy_io,
    output logic                              tx_ready_o,
    output logic                              rx_ready_o,
    output logic                              timeout_o,
    output logic [3:0]                        state_o
);

    localparam int CW = $clog2((g_timeout_cycles > g_ltd_stable ? g_timeout_cycles : g_ltd_stable) + 1);
    localparam logic [CW-1:0] ANA_LAST = CW'(g_analog_cycles - 1);
    localparam logic [CW-1:0] DIG_LAST = CW'(g_digital_cycles - 1);
    localparam logic [CW-1:0] LTD_LAST = CW'(g_ltd_stable - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(g_timeout_cycles - 1);

    logic [4:0]    raw, syn;
    logic          pll_s, tcal_s, rcal_s, ltr_s, ltd_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, stb_q, stb_d;
    logic          tmo_q, tmo_d, stb_cond, restart, rx_branch;
    ctrl_t         ctrl_q, ctrl_d;

    assign raw = {phy_io.pll_locked, phy_io.tx_cal_busy, phy_io.rx_cal_busy,
                  phy_io.rx_is_lockedtoref, phy_io.rx_is_lockedtodata};

    for (genvar g = 0; g < 5; g++) begin : g_sync
        wr_arria10_phy_rst_ctrl_sync #(.g_stages(g_sync_stages)) u_sync (
            .clk_i (clk_i),
            .d_i   (raw[g]),
            .q_o   (syn[g])
        );
    end

    assign {pll_s, tcal_s, rcal_s, ltr_s, ltd_s} = syn;

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stb_q   <= '0;
            tmo_q   <= 1'b0;
            ctrl_q  <= state_ctrl(S_IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            tmo_q   <= tmo_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state: cnt counts time in state (holds, timeouts); stb counts consecutive cycles
    // of the state's lock condition and drops to zero whenever that condition is lost.
    always_comb begin
        state_d   = state_q;
        tmo_d     = 1'b0;
        stb_cond  = 1'b0;
        rx_branch = state_q inside {S_RX_ANALOG, S_RX_LTR, S_RX_LTD, S_RX_DIGITAL, S_READY};
        case (state_q)
            S_IDLE:       state_d = S_WAIT_CAL;
            S_WAIT_CAL:   if (!tcal_s && !rcal_s) state_d = S_TX_ANALOG;
                          else if (cnt_q >= TMO_LAST) tmo_d = 1'b1;
            S_TX_ANALOG:  if (cnt_q >= ANA_LAST) state_d = S_TX_PLL;
            S_TX_PLL: begin
                stb_cond = pll_s;
                if (pll_s && stb_q >= DIG_LAST) state_d = S_RX_ANALOG;
                else if (cnt_q >= TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_TX_ANALOG;
                end
            end
            S_RX_ANALOG:  if (cnt_q >= ANA_LAST) state_d = S_RX_LTR;
            S_RX_LTR: begin
                stb_cond = ltr_s;
                if (ltr_s && stb_q >= DIG_LAST) state_d = S_RX_LTD;
                else if (cnt_q >= TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_RX_ANALOG;
                end
            end
            S_RX_LTD: begin
                stb_cond = ltd_s;
                if (ltd_s && stb_q >= LTD_LAST) state_d = S_RX_DIGITAL;
                else if (cnt_q >= TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_RX_ANALOG;
                end
            end
            S_RX_DIGITAL: begin
                stb_cond = ltd_s;
                if (ltd_s && stb_q >= DIG_LAST) state_d = S_READY;
            end
            S_READY:      if (!ltd_s) state_d = S_RX_ANALOG;
            default:      state_d = S_WAIT_CAL;
        endcase
        if (phy_rst_i || (state_q != S_WAIT_CAL && (tcal_s || rcal_s || (!pll_s && rx_branch)))) begin
            state_d = S_WAIT_CAL;
            tmo_d   = 1'b0;
        end
        restart = state_d != state_q || tmo_d || phy_rst_i;
        cnt_d   = restart ? '0 : (&cnt_q ? cnt_q : cnt_q + CW'(1));
        stb_d   = (restart || !stb_cond) ? '0 : (&stb_q ? stb_q : stb_q + CW'(1));
    end

    // Output decode of the next state so every pin is registered alongside the state.
    always_comb begin
        ctrl_d = state_ctrl(state_d);
    end

    assign phy_io.tx_analogreset    = ctrl_q.tx_ana_rst;
    assign phy_io.tx_digitalreset   = ctrl_q.tx_dig_rst;
    assign phy_io.rx_analogreset    = ctrl_q.rx_ana_rst;
    assign phy_io.rx_digitalreset   = ctrl_q.rx_dig_rst;
    assign phy_io.rx_set_locktoref  = ctrl_q.ltr;
    assign phy_io.rx_set_locktodata = 1'b0;
    assign tx_ready_o               = ctrl_q.tx_rdy;
    assign rx_ready_o               = ctrl_q.rx_rdy;
    assign timeout_o                = tmo_q;
    assign state_o                  = state_q;

endmodule
